// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: parametrised fetch-stage instruction memory with a one-word-per-cycle
// clear engine, fetch stall/hold, read-valid qualifier and out-of-range error pulses.
module instr_mem_ctrl #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 8,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    input  logic              write_signal,
    input  logic [31:0]       write_address,
    input  logic [DATA_W-1:0] instruction_write,
    input  logic              fetch_en,
    input  logic              stall,
    input  logic [31:0]       pc,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic              addr_err,
    output logic              wr_err,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d, aerr_q, aerr_d, werr_q, werr_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              pc_ok, wa_ok, mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    // any set bit above the index field means out of range
    assign pc_ok = (pc >> ADDR_W) == 32'd0;
    assign wa_ok = (write_address >> ADDR_W) == 32'd0;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        instr_d   = instr_q;
        valid_d   = 1'b0;
        aerr_d    = 1'b0;
        werr_d    = write_signal && (state_q == CLEAR || !wa_ok);
        mem_we    = 1'b0;
        mem_wa    = write_address[ADDR_W-1:0];
        mem_wd    = instruction_write;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_wa    = clr_ptr_q;
            mem_wd    = NOP_WORD;
            clr_ptr_d = clr_ptr_q + 1'b1;
            state_d   = &clr_ptr_q ? IDLE : CLEAR;
        end else begin
            mem_we = write_signal && wa_ok;
            if (clear_req) begin
                state_d   = CLEAR;
                clr_ptr_d = '0;
            end
            // the array read sees pre-edge contents, giving read-before-write
            if (stall) begin
                valid_d = valid_q;
            end else if (fetch_en) begin
                valid_d = 1'b1;
                aerr_d  = !pc_ok;
                instr_d = pc_ok ? mem[pc[ADDR_W-1:0]] : NOP_WORD;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            instr_q   <= NOP_WORD;
            valid_q   <= 1'b0;
            aerr_q    <= 1'b0;
            werr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            aerr_q    <= aerr_d;
            werr_q    <= werr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign addr_err    = aerr_q;
    assign wr_err      = werr_q;
    assign busy        = state_q == CLEAR;
endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb_instr_mem_ctrl: randomized and directed checks of instr_mem_ctrl against a
// behavioural model (word array plus a remaining-sweep-cycles count).
module tb_instr_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset, clear_req, write_signal, fetch_en, stall;
    logic [31:0] write_address, instruction_write, pc, instruction;
    logic        instr_valid, addr_err, wr_err, busy;

    int          n_cmp = 0, n_err = 0;
    logic [31:0] m_mem [256];
    logic [31:0] m_instr;
    logic        m_valid, m_aerr, m_werr;
    int          m_left;

    instr_mem_ctrl dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .write_signal(write_signal),
        .write_address(write_address), .instruction_write(instruction_write),
        .fetch_en(fetch_en), .stall(stall), .pc(pc), .instruction(instruction),
        .instr_valid(instr_valid), .addr_err(addr_err), .wr_err(wr_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic idle();
        clear_req = 0; write_signal = 0; write_address = 0; instruction_write = 0;
        fetch_en = 0; stall = 0; pc = 0;
    endtask

    task automatic m_reset();
        m_instr = 0; m_valid = 0; m_aerr = 0; m_werr = 0; m_left = 256;
        foreach (m_mem[i]) m_mem[i] = 0;
    endtask

    // advance the model by one clock from the current inputs, then clock the DUT
    task automatic tick();
        if (m_left > 0) begin
            m_valid = 0; m_aerr = 0; m_werr = write_signal; m_left--;
        end else begin
            m_werr = write_signal && write_address >= 256;
            if (stall) m_aerr = 0;
            else if (fetch_en) begin
                m_valid = 1;
                m_aerr  = pc >= 256;
                m_instr = pc < 256 ? m_mem[pc[7:0]] : 32'h0;
            end else begin
                m_valid = 0; m_aerr = 0;
            end
            if (write_signal && write_address < 256) m_mem[write_address[7:0]] = instruction_write;
            if (clear_req) begin
                m_left = 256;
                foreach (m_mem[i]) m_mem[i] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        idle(); fetch_en = 1; pc = a; tick(); idle();
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        idle(); write_signal = 1; write_address = a; instruction_write = d; tick(); idle();
    endtask

    task automatic test_reset();
        int cnt = 0;
        idle(); reset = 1; m_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (instruction !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", instruction); end
        n_cmp++; if (instr_valid !== 1'b0 || addr_err !== 1'b0 || wr_err !== 1'b0) begin n_err++; $display("FAIL reset_flags: got v=%b a=%b w=%b want 000", instr_valid, addr_err, wr_err); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", busy); end
        reset = 0;
        while (busy === 1'b1 && cnt < 1000) begin tick(); cnt++; end
        n_cmp++; if (cnt != 256) begin n_err++; $display("FAIL sweep_len: got %0d want 256", cnt); end
    endtask

    task automatic test_fetch_all();
        for (int p = 0; p < 256; p++) begin
            fetch(p);
            n_cmp++;
            if (instruction !== 32'h0 || instr_valid !== 1'b1) begin
                n_err++; $display("FAIL cleared_fetch pc=%0d: got %h v=%b want 0 v=1", p, instruction, instr_valid);
            end
        end
    endtask

    task automatic test_write_read();
        write(3, 32'hA5A50001);
        write(255, 32'hDEADBEEF);
        fetch(3);
        n_cmp++; if (instruction !== 32'hA5A50001 || instr_valid !== 1'b1) begin n_err++; $display("FAIL read3: got %h want a5a50001", instruction); end
        fetch(255);
        n_cmp++; if (instruction !== 32'hDEADBEEF || instr_valid !== 1'b1) begin n_err++; $display("FAIL read255: got %h want deadbeef", instruction); end
    endtask

    task automatic test_rbw();
        idle(); write_signal = 1; write_address = 7; instruction_write = 32'h11111111;
        fetch_en = 1; pc = 7; tick(); idle();
        n_cmp++; if (instruction !== 32'h0) begin n_err++; $display("FAIL rbw_old: got %h want 0", instruction); end
        fetch(7);
        n_cmp++; if (instruction !== 32'h11111111) begin n_err++; $display("FAIL rbw_new: got %h want 11111111", instruction); end
    endtask

    task automatic test_range();
        fetch(256);
        n_cmp++; if (instruction !== 32'h0 || instr_valid !== 1'b1 || addr_err !== 1'b1) begin n_err++; $display("FAIL oob_fetch: got %h v=%b a=%b want 0 v=1 a=1", instruction, instr_valid, addr_err); end
        tick();
        n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL addr_err_pulse: got %b want 0", addr_err); end
        write(300, 32'hCAFEF00D);
        n_cmp++; if (wr_err !== 1'b1) begin n_err++; $display("FAIL wr_err_oob: got %b want 1", wr_err); end
        tick();
        n_cmp++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL wr_err_pulse: got %b want 0", wr_err); end
        fetch(44);
        n_cmp++; if (instruction !== m_mem[44]) begin n_err++; $display("FAIL alias44: got %h want %h", instruction, m_mem[44]); end
    endtask

    task automatic test_stall();
        fetch(3);
        n_cmp++; if (instruction !== 32'hA5A50001) begin n_err++; $display("FAIL stall_pre: got %h want a5a50001", instruction); end
        for (int i = 0; i < 4; i++) begin
            stall = 1; fetch_en = $urandom_range(0, 1); pc = $urandom; tick();
            n_cmp++;
            if (instruction !== 32'hA5A50001 || instr_valid !== 1'b1 || addr_err !== 1'b0) begin
                n_err++; $display("FAIL stall_hold: got %h v=%b a=%b want a5a50001 v=1 a=0", instruction, instr_valid, addr_err);
            end
        end
        idle(); tick();
        n_cmp++; if (instr_valid !== 1'b0 || instruction !== 32'hA5A50001) begin n_err++; $display("FAIL no_fetch: got %h v=%b want a5a50001 v=0", instruction, instr_valid); end
    endtask

    task automatic test_mid_clear_reset();
        int cnt = 0;
        idle(); clear_req = 1; tick(); idle();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL clear_start: got %b want 1", busy); end
        repeat (99) tick();
        reset = 1; m_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            if (cnt == 50) begin write_signal = 1; write_address = 10; instruction_write = 32'h12345678; end
            tick(); cnt++;
            if (cnt == 51) begin
                n_cmp++; if (wr_err !== 1'b1) begin n_err++; $display("FAIL wr_err_busy: got %b want 1", wr_err); end
                idle();
            end
        end
        n_cmp++; if (cnt != 256) begin n_err++; $display("FAIL restart_len: got %0d want 256", cnt); end
        fetch(255);
        n_cmp++; if (instruction !== 32'h0) begin n_err++; $display("FAIL post_clear255: got %h want 0", instruction); end
        fetch(10);
        n_cmp++; if (instruction !== 32'h0) begin n_err++; $display("FAIL busy_write_dropped: got %h want 0", instruction); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            write_signal      = 1'($urandom_range(0, 1));
            write_address     = $urandom_range(0, 9) == 0 ? $urandom : $urandom_range(0, 15);
            instruction_write = $urandom;
            fetch_en          = $urandom_range(0, 3) != 0;
            stall             = $urandom_range(0, 4) == 0;
            pc                = $urandom_range(0, 9) == 0 ? $urandom : $urandom_range(0, 15);
            clear_req         = $urandom_range(0, 199) == 0;
            tick();
            n_cmp++;
            if (instruction !== m_instr || instr_valid !== m_valid || addr_err !== m_aerr ||
                wr_err !== m_werr || busy !== (m_left > 0)) begin
                n_err++;
                $display("FAIL random[%0d]: got i=%h v=%b a=%b w=%b b=%b want i=%h v=%b a=%b w=%b b=%b", i,
                         instruction, instr_valid, addr_err, wr_err, busy,
                         m_instr, m_valid, m_aerr, m_werr, m_left > 0);
            end
        end
        idle();
        while (m_left > 0) tick();
    endtask

    initial begin
        test_reset();
        test_fetch_all();
        test_write_read();
        test_rbw();
        test_range();
        test_stall();
        test_mid_clear_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
